// File: rtl/sort_job_scheduler.sv
// Two-requester front end for a streaming sorter: arbitrates jobs, clears
// the sorter, feeds it the owner's elements and returns the sorted stream.
module sort_job_scheduler #(
    parameter int DATA_WIDTH       = 8,
    parameter int ELEMENT_NUM      = 16,
    parameter int LOG2_ELEMENT_NUM = 4,
    parameter int CLR_CYCLES       = 2,
    parameter int TIMEOUT          = 255
) (
    input  logic                        clk_mn,
    input  logic                        rst,
    input  logic                        req0,
    input  logic                        req1,
    output logic                        grant0,
    output logic                        grant1,
    input  logic                        ld_valid0,
    input  logic                        ld_valid1,
    input  logic [DATA_WIDTH-1:0]       ld_data0,
    input  logic [DATA_WIDTH-1:0]       ld_data1,
    output logic                        ld_ready,
    output logic                        srt_rst,
    output logic                        srt_valid,
    output logic [DATA_WIDTH-1:0]       srt_data,
    input  logic                        sm_valid,
    input  logic [LOG2_ELEMENT_NUM-1:0] sm_addr,
    input  logic [DATA_WIDTH-1:0]       sm_data,
    input  logic                        sm_done,
    output logic                        out_valid0,
    output logic                        out_valid1,
    output logic [LOG2_ELEMENT_NUM-1:0] out_addr,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        job_done0,
    output logic                        job_done1,
    output logic                        err
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD, SORT, DRAIN, FINISH
    } state_t;

    localparam int CW = LOG2_ELEMENT_NUM + 1;
    localparam logic [CW-1:0] ELEM_MAX  = CW'(ELEMENT_NUM);
    localparam logic [CW-1:0] ELEM_LAST = CW'(ELEMENT_NUM - 1);
    localparam logic [3:0]    CLR_LAST  = 4'(CLR_CYCLES - 1);
    localparam logic [15:0]   TMO_LAST  = 16'(TIMEOUT - 1);

    state_t                state;
    logic                  owner;
    logic                  last_owner;
    logic [CW-1:0]         elem_cnt;
    logic [3:0]            clr_cnt;
    logic [15:0]           tmo_cnt;
    logic                  own_valid;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  accept;
    logic                  pick;

    assign own_valid = owner ? ld_valid1 : ld_valid0;
    assign own_data  = owner ? ld_data1 : ld_data0;
    assign accept    = (state == LOAD) && own_valid && (elem_cnt < ELEM_MAX);
    assign ld_ready  = accept;
    assign srt_rst   = (state == IDLE) || (state == CLEAR);

    // On contention the requester that did not own the last job wins
    assign pick = (req0 && req1) ? !last_owner : req1;

    always_ff @(posedge clk_mn or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            grant0     <= 1'b0;
            grant1     <= 1'b0;
            elem_cnt   <= '0;
            clr_cnt    <= '0;
            tmo_cnt    <= '0;
            srt_valid  <= 1'b0;
            srt_data   <= '0;
            out_valid0 <= 1'b0;
            out_valid1 <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            job_done0  <= 1'b0;
            job_done1  <= 1'b0;
            err        <= 1'b0;
        end else begin
            srt_valid  <= 1'b0;
            out_valid0 <= 1'b0;
            out_valid1 <= 1'b0;
            job_done0  <= 1'b0;
            job_done1  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner   <= pick;
                        grant0  <= !pick;
                        grant1  <= pick;
                        clr_cnt <= '0;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        elem_cnt <= '0;
                        state    <= LOAD;
                    end else begin
                        clr_cnt <= clr_cnt + 4'd1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        srt_valid <= 1'b1;
                        srt_data  <= own_data;
                        elem_cnt  <= elem_cnt + 1'b1;
                        if (elem_cnt == ELEM_LAST) begin
                            tmo_cnt <= '0;
                            state   <= SORT;
                        end
                    end
                end
                SORT: begin
                    if (sm_valid) begin
                        out_valid0 <= !owner;
                        out_valid1 <= owner;
                        out_addr   <= sm_addr;
                        out_data   <= sm_data;
                        if (sm_done) begin
                            job_done0 <= !owner;
                            job_done1 <= owner;
                            state     <= FINISH;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Sorter stalled: flag it and retry the same owner
                        err     <= 1'b1;
                        clr_cnt <= '0;
                        state   <= CLEAR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                DRAIN: begin
                    if (sm_valid) begin
                        out_valid0 <= !owner;
                        out_valid1 <= owner;
                        out_addr   <= sm_addr;
                        out_data   <= sm_data;
                    end
                    if (sm_done) begin
                        job_done0 <= !owner;
                        job_done1 <= owner;
                        state     <= FINISH;
                    end
                end
                FINISH: begin
                    grant0     <= 1'b0;
                    grant1     <= 1'b0;
                    last_owner <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
